booth_r8_seq_mult: RTL and testbench

//  Sequential signed radix-8 Booth multiplier front end and accumulator, wrapped around the existing booth selector stage.
//  - Latches multiplicand x and multiplier y on start. Forms tx = 3*x.
//  - Presents one 4-bit Booth window per cycle to an internal booth instance (parameter m).
//  - Accumulates each signed partial product, shifted left by 3*i, into a 2m-bit product.
//  - Sits between an operand source (start/busy/done handshake) and the product consumer.

---
 rtl/booth_r8_seq_mult_if.sv | 13 +
 rtl/booth_r8_seq_mult.sv | 131 +++++++++++++
 tb/tb_booth_r8_seq_mult.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/booth_r8_seq_mult_if.sv
// Operand/product handshake bundle for booth_r8_seq_mult.
// The master side is the operand source and product consumer; the slave side is the multiplier.
interface booth_r8_seq_mult_if #(parameter int m = 8);
  logic                  start;
  logic signed [m-1:0]   x;
  logic signed [m-1:0]   y;
  logic                  busy;
  logic                  done;
  logic signed [2*m-1:0] product;

  modport master (output start, x, y, input busy, done, product);
  modport slave  (input start, x, y, output busy, done, product);
endinterface

// File: rtl/booth_r8_seq_mult.sv
// Sequential signed radix-8 Booth multiplier: one 4-bit multiplier window per RUN cycle into a 2m-bit accumulator.
// Optional macro BOOTH_SEQ_EARLY_TERM_EN ends RUN once every remaining window is 0000 or 1111.

module booth #(parameter int m = 8) (
  input  logic [3:0]          window,
  input  logic signed [m-1:0] xr,
  input  logic signed [m+1:0] tx,
  output logic signed [m+2:0] pp
);
  // One bit wider than m+2 so that -4 * -2^(m-1) = +2^(m+1) is still representable.
  logic signed [m+2:0] x1;
  logic signed [m+2:0] x3;

  assign x1 = (m+3)'(xr);
  assign x3 = (m+3)'(tx);

  always_comb begin
    pp = '0;
    case (window)
      4'b0001, 4'b0010: pp = x1;
      4'b0011, 4'b0100: pp = x1 <<< 1;
      4'b0101, 4'b0110: pp = x3;
      4'b0111:          pp = x1 <<< 2;
      4'b1000:          pp = -(x1 <<< 2);
      4'b1001, 4'b1010: pp = -x3;
      4'b1011, 4'b1100: pp = -(x1 <<< 1);
      4'b1101, 4'b1110: pp = -x1;
      default:          pp = '0;
    endcase
  end
endmodule

module booth_r8_seq_mult #(parameter int m = 8) (
  input logic               clk,
  input logic               rst,
  booth_r8_seq_mult_if.slave bus
);
  localparam int N  = (m + 2) / 3;
  localparam int YW = 3 * N + 1;
  localparam int PW = 2 * m;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(3 * N);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state;
  state_t next_state;

  logic signed [m-1:0]   xr;
  logic [YW-1:0]         ye;
  logic signed [PW-1:0]  acc;
  logic signed [PW-1:0]  product_q;
  logic [CW-1:0]         cnt;
  logic [SW-1:0]         shamt;

  logic                  accept;
  logic                  last_grp;
  logic                  finish;
  logic signed [m+1:0]   tx;
  logic signed [m+2:0]   pp;
  logic signed [PW-1:0]  pp_shift;
  logic signed [PW-1:0]  acc_next;
  logic signed [3*N-1:0] y_ext;

  assign accept   = bus.start && (state == IDLE || state == DONE);
  assign last_grp = (cnt == CW'(N - 1));
  assign y_ext    = (3*N)'(bus.y);
  assign tx       = (m+2)'(xr) + ((m+2)'(xr) <<< 1);
  assign pp_shift = PW'(pp) <<< shamt;
  assign acc_next = acc + pp_shift;

  // ye is shifted right by one group per cycle, so the current window is always its low nibble.
  booth #(.m(m)) u_booth (
    .window (ye[3:0]),
    .xr     (xr),
    .tx     (tx),
    .pp     (pp)
  );

`ifdef BOOTH_SEQ_EARLY_TERM_EN
  assign finish = last_grp || (&ye[YW-1:3]) || !(|ye[YW-1:3]);
`else
  assign finish = last_grp;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.start) next_state = RUN;
      RUN:     if (finish)    next_state = DONE;
      DONE:    next_state = bus.start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state == RUN);
    bus.done = (state == DONE);
  end

  assign bus.product = product_q;

  // Operands are captured only on an accepted start, so input changes while busy are invisible.
  always_ff @(posedge clk) begin
    if (rst) begin
      xr        <= '0;
      ye        <= '0;
      acc       <= '0;
      cnt       <= '0;
      shamt     <= '0;
      product_q <= '0;
    end else if (accept) begin
      xr    <= bus.x;
      ye    <= {y_ext, 1'b0};
      acc   <= '0;
      cnt   <= '0;
      shamt <= '0;
    end else if (state == RUN) begin
      acc   <= acc_next;
      cnt   <= cnt + CW'(1);
      shamt <= shamt + SW'(3);
      ye    <= {{3{ye[YW-1]}}, ye[YW-1:3]};
      if (finish) product_q <= acc_next;
    end
  end
endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// Self-checking bench for booth_r8_seq_mult: directed vector table, hand-written corner sequences and random operands.
// Expected products come from plain integer multiplication; latency from the operand-range rule.
module tb_booth_r8_seq_mult;
  localparam int M = 8;
  localparam int N = (M + 2) / 3;

  typedef struct {
    int x;
    int y;
    int prod;
    int lat_fixed;
    int lat_et;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   held  = 0;

  booth_r8_seq_mult_if #(.m(M)) bus ();

  booth_r8_seq_mult #(.m(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic signed [31:0] act, input int exp);
    n_cmp++;
    if (act !== 32'(exp)) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Early termination ends after group k, the first group beyond which y is pure sign extension.
  function automatic int model_lat(input int yv);
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    for (int i = 0; i < N; i++) begin
      if (yv >= -(1 <<< (3*i + 2)) && yv < (1 <<< (3*i + 2))) return i + 2;
    end
    return N + 1;
`else
    if (yv == yv + 1) return 0;
    return N + 1;
`endif
  endfunction

  task automatic applyStimulus(input int a, input int b, input bit immediate);
    if (!immediate) begin
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.x = 8'(a);
      bus.y = 8'(b);
      @(negedge clk);
      checkOutput("gap_done",     32'(bus.done), 0);
      checkOutput("gap_busy",     32'(bus.busy), 0);
      checkOutput("product_hold", 32'($signed(bus.product)), held);
    end else begin
      bus.start = 1'b1;
      bus.x = 8'(a);
      bus.y = 8'(b);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.x = 8'($urandom);
    bus.y = 8'($urandom);
  endtask

  task automatic runOp(input int a, input int b, input int exp_p, input int exp_lat,
                       input bit immediate, input string tag);
    int lat;
    bit seen;
    applyStimulus(a, b, immediate);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= N + 4) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        checkOutput({tag, "_busy"}, 32'(bus.busy), (lat < exp_lat) ? 1 : 0);
        @(posedge clk); #1;
        lat++;
        if (lat < exp_lat) begin
          bus.start = 1'($urandom);
          bus.x = 8'($urandom);
          bus.y = 8'($urandom);
        end else begin
          bus.start = 1'b0;
        end
      end
    end
    checkOutput({tag, "_latency"}, seen ? 32'(lat) : -1, exp_lat);
    if (seen) begin
      checkOutput({tag, "_busy_at_done"}, 32'(bus.busy), 0);
      checkOutput({tag, "_product"}, 32'($signed(bus.product)), exp_p);
    end
    held = exp_p;
  endtask

  initial begin
    vec_t vecs[9];
    int exp_lat;
    logic signed [7:0] ra;
    logic signed [7:0] rb;

    vecs[0] = '{x:    7, y:   -3, prod:    -21, lat_fixed: 4, lat_et: 2};
    vecs[1] = '{x: -128, y: -128, prod:  16384, lat_fixed: 4, lat_et: 4};
    vecs[2] = '{x:  127, y: -128, prod: -16256, lat_fixed: 4, lat_et: 4};
    vecs[3] = '{x: -128, y:  127, prod: -16256, lat_fixed: 4, lat_et: 4};
    vecs[4] = '{x:  127, y:  127, prod:  16129, lat_fixed: 4, lat_et: 4};
    vecs[5] = '{x:    5, y:    3, prod:     15, lat_fixed: 4, lat_et: 2};
    vecs[6] = '{x:    9, y:   -1, prod:     -9, lat_fixed: 4, lat_et: 2};
    vecs[7] = '{x:    2, y:  100, prod:    200, lat_fixed: 4, lat_et: 4};
    vecs[8] = '{x: -128, y:    4, prod:   -512, lat_fixed: 4, lat_et: 3};

    // Reset held for two edges while start is asserted.
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.x     = 8'sd7;
    bus.y     = 8'sd7;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy",    32'(bus.busy), 0);
    checkOutput("reset_done",    32'(bus.done), 0);
    checkOutput("reset_product", 32'($signed(bus.product)), 0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(bus.busy), 0);
    checkOutput("post_reset_done", 32'(bus.done), 0);
    held = 0;

    for (int i = 0; i < 9; i++) begin
`ifdef BOOTH_SEQ_EARLY_TERM_EN
      exp_lat = vecs[i].lat_et;
`else
      exp_lat = vecs[i].lat_fixed;
`endif
      runOp(vecs[i].x, vecs[i].y, vecs[i].prod, exp_lat, 1'b0, $sformatf("vec%0d", i));
    end

    runOp(5, 3, 15, model_lat(3), 1'b0, "b2b_first");
    runOp(-6, 9, -54, model_lat(9), 1'b1, "b2b_second");

    // Reset asserted during cycle 2 of an operation discards it.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.x = 8'sd100;
    bus.y = -8'sd77;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_busy",    32'(bus.busy), 0);
    checkOutput("midrst_done",    32'(bus.done), 0);
    checkOutput("midrst_product", 32'($signed(bus.product)), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_no_done", 32'(bus.done), 0);
    held = 0;
    runOp(3, 4, 12, model_lat(4), 1'b0, "after_rst");

    for (int i = 0; i < 10000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      runOp(int'(ra), int'(rb), int'(ra) * int'(rb), model_lat(int'(rb)),
            1'($urandom_range(0, 1)), "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
